mem_scan_ctrl: RTL and testbench

//  Parametrised scan controller around a single-port synchronous RAM. On Start, it walks
//  an address window [Base..Last] (wrapping mod 2**ADDR_W), reading or writing one word per

---
 rtl/mem_scan_pkg.sv | 23 ++
 rtl/mem_scan_ctrl_if.sv | 32 +++
 rtl/sync_ram.sv | 26 ++
 rtl/mem_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_mem_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types for the memory scan controller: scan modes, FSM states and a mode helper.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        RD_ONCE = 2'd0,
        RD_LOOP = 2'd1,
        WR_FILL = 2'd2,
        WR_RAMP = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Both write modes share the upper mode bit.
    function automatic logic is_write(input mode_t m);
        return m[1];
    endfunction

endpackage

// File: rtl/mem_scan_ctrl_if.sv
// Control/data bundle between a scan requester (master) and the scan controller (slave).
interface mem_scan_ctrl_if
    import mem_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) ();

    logic              start;
    mode_t             mode;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] last;
    logic [DATA_W-1:0] w_data;
    logic              hold;
    logic              stop;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, mode, base, last, w_data, hold, stop,
        input  r_data, r_valid, r_addr, busy, done
    );

    modport slave (
        input  start, mode, base, last, w_data, hold, stop,
        output r_data, r_valid, r_addr, busy, done
    );

endinterface

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read; a read during a write returns the old word.
module sync_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_reg;

    // Write port plus registered read of the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: walks a wrapping address window reading or writing one word per cycle.
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_scan_ctrl_if.slave bus
);

    localparam logic [1:0]      S_IDLE  = IDLE;
    localparam logic [1:0]      S_RUN   = RUN;
    localparam logic [1:0]      S_DRAIN = DRAIN;
    localparam logic [1:0]      S_DONE  = DONE;
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

    logic [1:0]        state_reg, state_next;
    mode_t             mode_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   len_reg;       // accesses left in the current pass
    logic [ADDR_W:0]   len_init_reg;  // window length, reloaded on each loop pass
    logic              rd_valid_reg;
    logic [ADDR_W-1:0] rd_addr_reg;

    logic              load;
    logic              issue;
    logic              last_access;
    logic [ADDR_W:0]   win_len;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Window length (1..2**ADDR_W); the subtraction wraps in ADDR_W bits before extension.
    assign win_len     = {1'b0, bus.last - bus.base} + LEN_ONE;
    assign load        = (state_reg == S_IDLE) && bus.start;
    assign issue       = (state_reg == S_RUN) && !bus.hold;
    assign last_access = (len_reg == LEN_ONE);
    assign ram_we      = issue && is_write(mode_reg);
    assign ram_wdata   = (mode_reg == WR_FILL) ? bus.w_data : DATA_W'(addr_reg);

    // Next-state selection; Stop ends the scan even while Hold is asserted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN: begin
                if (bus.stop) begin
                    state_next = S_DRAIN;
                end else if (issue && last_access && (mode_reg != RD_LOOP)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register, request latching and address/length counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            mode_reg     <= RD_ONCE;
            base_reg     <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            len_init_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                mode_reg     <= bus.mode;
                base_reg     <= bus.base;
                addr_reg     <= bus.base;
                len_reg      <= win_len;
                len_init_reg <= win_len;
            end else if (issue) begin
                if (last_access) begin
                    // Back to the start of the window with no bubble (only matters in loop mode).
                    addr_reg <= base_reg;
                    len_reg  <= len_init_reg;
                end else begin
                    addr_reg <= addr_reg + 1'b1;
                    len_reg  <= len_reg - LEN_ONE;
                end
            end
        end
    end

    // One-stage valid/address pipeline aligned with the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_addr_reg  <= '0;
        end else begin
            rd_valid_reg <= issue && !is_write(mode_reg);
            if (issue) begin
                rd_addr_reg <= addr_reg;
            end
        end
    end

    sync_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_reg),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RAM output is masked so the data port reads zero whenever no beat is presented.
    assign bus.r_data  = rd_valid_reg ? ram_rdata : '0;
    assign bus.r_valid = rd_valid_reg;
    assign bus.r_addr  = rd_addr_reg;
    assign bus.busy    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign bus.done    = (state_reg == S_DONE);

endmodule

// File: tb/tb_mem_scan_ctrl.sv
// Self-checking bench for mem_scan_ctrl: directed scenarios plus randomized scans against a RAM model.
module tb_mem_scan_ctrl;
    import mem_scan_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_scan_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    mem_scan_ctrl #(.DATA_W(16), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference memory contents and window-level expectations
    logic [15:0] model [256];
    logic [7:0]  exp_addr [$];
    logic [15:0] exp_data [$];

    // Observations collected by run_scan
    logic [7:0]  cap_addr [$];
    logic [15:0] cap_data [$];
    int busy_cycles, done_count, done_cyc, last_beat_cyc, overlap_count, stray_count;
    bit timed_out;

    function automatic int win_len(input logic [7:0] b, input logic [7:0] l);
        return ((int'(l) - int'(b) + 256) % 256) + 1;
    endfunction

    // Expected read sequence: 'count' accesses cycling through the window from Base.
    function automatic void build_expected(input logic [7:0] b, input logic [7:0] l, input int count);
        int n;
        logic [7:0] a;
        n = win_len(b, l);
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < count; i++) begin
            a = 8'((int'(b) + (i % n)) % 256);
            exp_addr.push_back(a);
            exp_data.push_back(model[a]);
        end
    endfunction

    function automatic void model_write(input logic [7:0] b, input logic [7:0] l,
                                        input bit fill, input logic [15:0] wd);
        logic [7:0] a;
        for (int i = 0; i < win_len(b, l); i++) begin
            a = 8'((int'(b) + i) % 256);
            model[a] = fill ? wd : {8'h00, a};
        end
    endfunction

    // Drives one scan request and records everything the DUT presents until Done.
    task automatic run_scan(input mode_t m, input logic [7:0] b, input logic [7:0] l,
                            input logic [15:0] wd, input int hold_from, input int hold_len,
                            input int stop_at, input int restart_at, input bit rnd_hold);
        cap_addr.delete();
        cap_data.delete();
        busy_cycles = 0; done_count = 0; done_cyc = -1; last_beat_cyc = -1;
        overlap_count = 0; stray_count = 0; timed_out = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.base = b; bus.last = l; bus.w_data = wd;
        bus.hold = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int j = 1; j <= 3000; j++) begin
            if (bus.r_valid) begin
                cap_addr.push_back(bus.r_addr);
                cap_data.push_back(bus.r_data);
                last_beat_cyc = j;
            end
            if (bus.busy) busy_cycles++;
            if (bus.busy && bus.done) overlap_count++;
            if (bus.done) begin
                done_count++;
                done_cyc = j;
                timed_out = 1'b0;
                break;
            end
            bus.hold  = rnd_hold ? ($urandom_range(0, 3) == 0)
                                 : (j >= hold_from && j < hold_from + hold_len);
            bus.stop  = (j == stop_at);
            bus.start = (j == restart_at);
            bus.base  = (j == restart_at) ? b + 8'd5 : b;
            @(negedge clk);
        end
        bus.hold = 1'b0; bus.stop = 1'b0; bus.start = 1'b0; bus.base = b;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.r_valid) stray_count++;
        end
        if (timed_out) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: no done after 3000 cycles (mode %0d base %0d last %0d)", m, b, l);
        end
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.r_valid} !== 3'b000) begin
            n_err++; $display("FAIL reset_outputs: got busy/done/valid %b, expected 000",
                              {bus.busy, bus.done, bus.r_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = RD_ONCE; bus.base = 8'd0; bus.last = 8'd255;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.r_valid} !== 2'b11) begin
            n_err++; $display("FAIL reset_prescan: got busy/valid %b, expected 11", {bus.busy, bus.r_valid});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.r_valid} !== 3'b000 || bus.r_addr !== 8'd0 || bus.r_data !== 16'd0) begin
            n_err++; $display("FAIL reset_async: got busy %b done %b valid %b addr %0d data %h, expected all 0",
                              bus.busy, bus.done, bus.r_valid, bus.r_addr, bus.r_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.r_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL reset_idle_after: got %0d active cycles, expected 0", seen);
        end
    endtask

    task automatic test_ramp_full();
        run_scan(WR_RAMP, 8'd0, 8'd255, 16'h0000, 0, 0, -1, -1, 1'b0);
        n_cmp++;
        if (cap_addr.size() !== 0 || busy_cycles !== 257) begin
            n_err++; $display("FAIL ramp_write: got beats %0d busy %0d, expected beats 0 busy 257",
                              cap_addr.size(), busy_cycles);
        end
        model_write(8'd0, 8'd255, 1'b0, 16'h0000);
        run_scan(RD_ONCE, 8'd0, 8'd255, 16'h0000, 0, 0, -1, -1, 1'b0);
        build_expected(8'd0, 8'd255, 256);
        n_cmp++;
        if (cap_addr.size() !== 256) begin
            n_err++; $display("FAIL ramp_read_count: got %0d beats, expected 256", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 256; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL ramp_read_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (busy_cycles !== 257 || done_cyc - last_beat_cyc !== 1 || done_count !== 1 || overlap_count !== 0) begin
            n_err++; $display("FAIL ramp_read_timing: got busy %0d gap %0d dones %0d overlap %0d, expected 257 1 1 0",
                              busy_cycles, done_cyc - last_beat_cyc, done_count, overlap_count);
        end
    endtask

    task automatic test_fill_wrap();
        run_scan(WR_FILL, 8'd250, 8'd3, 16'hA5A5, 0, 0, -1, -1, 1'b0);
        n_cmp++;
        if (cap_addr.size() !== 0 || busy_cycles !== 11) begin
            n_err++; $display("FAIL fill_write: got beats %0d busy %0d, expected beats 0 busy 11",
                              cap_addr.size(), busy_cycles);
        end
        model_write(8'd250, 8'd3, 1'b1, 16'hA5A5);
        run_scan(RD_ONCE, 8'd248, 8'd5, 16'h0000, 0, 0, -1, -1, 1'b0);
        build_expected(8'd248, 8'd5, 14);
        n_cmp++;
        if (cap_addr.size() !== 14) begin
            n_err++; $display("FAIL fill_read_count: got %0d beats, expected 14", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 14; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL fill_read_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_hold();
        run_scan(RD_ONCE, 8'd10, 8'd20, 16'h0000, 4, 3, -1, -1, 1'b0);
        build_expected(8'd10, 8'd20, 11);
        n_cmp++;
        if (cap_addr.size() !== 11) begin
            n_err++; $display("FAIL hold_count: got %0d beats, expected 11", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 11; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL hold_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (busy_cycles !== 15 || done_cyc - last_beat_cyc !== 1) begin
            n_err++; $display("FAIL hold_busy: got busy %0d gap %0d, expected busy 15 gap 1",
                              busy_cycles, done_cyc - last_beat_cyc);
        end
    endtask

    task automatic test_loop_stop();
        run_scan(RD_LOOP, 8'd7, 8'd9, 16'h0000, 0, 0, 8, -1, 1'b0);
        build_expected(8'd7, 8'd9, 8);
        n_cmp++;
        if (cap_addr.size() !== 8) begin
            n_err++; $display("FAIL loop_count: got %0d beats, expected 8", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 8; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL loop_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_cmp++;
        if (done_count !== 1 || done_cyc - last_beat_cyc !== 1 || stray_count !== 0) begin
            n_err++; $display("FAIL loop_done: got dones %0d gap %0d stray %0d, expected 1 1 0",
                              done_count, done_cyc - last_beat_cyc, stray_count);
        end
    endtask

    task automatic test_start_busy();
        run_scan(RD_ONCE, 8'd42, 8'd42, 16'h0000, 0, 0, -1, 1, 1'b0);
        n_cmp++;
        if (cap_addr.size() !== 1) begin
            n_err++; $display("FAIL single_count: got %0d beats, expected 1", cap_addr.size());
        end else begin
            n_cmp++;
            if (cap_addr[0] !== 8'd42 || cap_data[0] !== model[42]) begin
                n_err++; $display("FAIL single_beat: got addr %0d data %h, expected addr 42 data %h",
                                  cap_addr[0], cap_data[0], model[42]);
            end
        end
        n_cmp++;
        if (busy_cycles !== 2 || done_count !== 1 || stray_count !== 0 || overlap_count !== 0) begin
            n_err++; $display("FAIL single_handshake: got busy %0d dones %0d stray %0d overlap %0d, expected 2 1 0 0",
                              busy_cycles, done_count, stray_count, overlap_count);
        end
    endtask

    task automatic test_random();
        mode_t m;
        logic [7:0] b, l;
        logic [15:0] wd;
        int n;
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0:       m = WR_FILL;
                1:       m = WR_RAMP;
                default: m = RD_ONCE;
            endcase
            b  = 8'($urandom_range(0, 255));
            l  = 8'($urandom_range(0, 255));
            wd = 16'($urandom);
            n  = win_len(b, l);
            run_scan(m, b, l, wd, 0, 0, -1, -1, 1'b1);
            if (is_write(m)) begin
                n_cmp++;
                if (cap_addr.size() !== 0 || done_count !== 1) begin
                    n_err++; $display("FAIL rand%0d_write: got beats %0d dones %0d, expected 0 1",
                                      t, cap_addr.size(), done_count);
                end
                model_write(b, l, m == WR_FILL, wd);
            end else begin
                build_expected(b, l, n);
                n_cmp++;
                if (cap_addr.size() !== n || done_count !== 1 || done_cyc - last_beat_cyc !== 1) begin
                    n_err++; $display("FAIL rand%0d_read: got beats %0d dones %0d gap %0d, expected %0d 1 1",
                                      t, cap_addr.size(), done_count, done_cyc - last_beat_cyc, n);
                end
                for (int i = 0; i < cap_addr.size() && i < n; i++) begin
                    n_cmp++;
                    if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                        n_err++; $display("FAIL rand%0d_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                          t, i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
        end
        run_scan(RD_ONCE, 8'd0, 8'd255, 16'h0000, 0, 0, -1, -1, 1'b1);
        build_expected(8'd0, 8'd255, 256);
        n_cmp++;
        if (cap_addr.size() !== 256) begin
            n_err++; $display("FAIL final_count: got %0d beats, expected 256", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 256; i++) begin
            n_cmp++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_err++; $display("FAIL final_beat%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = RD_ONCE; bus.base = 8'd0; bus.last = 8'd0;
        bus.w_data = 16'd0; bus.hold = 1'b0; bus.stop = 1'b0;
        test_reset();
        test_ramp_full();
        test_fill_wrap();
        test_hold();
        test_loop_stop();
        test_start_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
